// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU controller: states, opcodes,
// datapath select encodings and the decode dispatch helper.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic       ADDR_PC  = 1'b0;
  localparam logic       ADDR_ALU = 1'b1;

  localparam logic       PC_SRC_SEQ = 1'b0;
  localparam logic       PC_SRC_TGT = 1'b1;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_RS1    = 2'd1;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // Unrecognised opcodes land in TRAP straight from DECODE.
  function automatic state_t dispatch(input logic [6:0] opcode);
    case (opcode)
      OP_RTYPE:          return EXEC_R;
      OP_ITYPE:          return EXEC_I;
      OP_LOAD, OP_STORE: return MEM_ADDR;
      OP_BRANCH:         return BRANCH;
      OP_JAL:            return JAL;
      OP_JALR:           return JALR;
      default:           return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/retire_counter.sv
// 32-bit retired-instruction counter; wraps naturally, clears on async reset.
module retire_counter #(
  parameter logic [31:0] INIT = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= INIT;
    else if (en)
      count <= count + 32'd1;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM with memory-wait timeout, sticky trap
// and a retired-instruction counter.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX    = 15,
  parameter logic [31:0] RETIRE_CNT_INIT = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        i_or_d_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        reg_write_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  wb_sel_o,
  output logic        retire_o,
  output logic [31:0] retired_cnt_o,
  output logic        trap_o,
  output logic [3:0]  state_o
);

  localparam logic [7:0] WAIT_LIMIT = MEM_WAIT_MAX[7:0];

  state_t     state;
  state_t     next_state;
  logic       started;
  logic [7:0] wait_cnt;
  logic       mem_req;
  logic       timeout;

  assign mem_req = mem_read_o | mem_write_o;
  assign timeout = (wait_cnt == WAIT_LIMIT) && !mem_ready_i;

  // started keeps every enable low until the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= FETCH;
      started  <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      started <= 1'b1;
      if (started)
        state <= next_state;
      if (!started || next_state != state)
        wait_cnt <= 8'd0;
      else if (mem_req && !mem_ready_i)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    next_state  = state;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    i_or_d_o    = ADDR_PC;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = PC_SRC_SEQ;
    reg_write_o = 1'b0;
    alu_src_a_o = SRC_A_PC;
    alu_src_b_o = SRC_B_RT;
    alu_op_o    = ALU_ADD;
    wb_sel_o    = WB_SEL_ALU;
    retire_o    = 1'b0;
    trap_o      = 1'b0;
    if (started) begin
      case (state)
        FETCH: begin
          mem_read_o  = 1'b1;
          i_or_d_o    = ADDR_PC;
          alu_src_a_o = SRC_A_PC;
          alu_src_b_o = SRC_B_FOUR;
          alu_op_o    = ALU_ADD;
          pc_src_o    = PC_SRC_SEQ;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            next_state = DECODE;
          end else if (timeout) begin
            next_state = TRAP;
          end
        end
        DECODE: begin
          alu_src_a_o = SRC_A_OLD_PC;
          alu_src_b_o = SRC_B_IMM;
          alu_op_o    = ALU_ADD;
          next_state  = dispatch(opcode_i);
        end
        EXEC_R: begin
          alu_src_a_o = SRC_A_RS1;
          alu_src_b_o = SRC_B_RT;
          alu_op_o    = ALU_FUNCT;
          next_state  = WB_ALU;
        end
        EXEC_I: begin
          alu_src_a_o = SRC_A_RS1;
          alu_src_b_o = SRC_B_IMM;
          alu_op_o    = ALU_FUNCT;
          next_state  = WB_ALU;
        end
        WB_ALU: begin
          reg_write_o = 1'b1;
          wb_sel_o    = WB_SEL_ALU;
          retire_o    = 1'b1;
          next_state  = FETCH;
        end
        MEM_ADDR: begin
          alu_src_a_o = SRC_A_RS1;
          alu_src_b_o = SRC_B_IMM;
          alu_op_o    = ALU_ADD;
          next_state  = (opcode_i == OP_LOAD) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem_read_o = 1'b1;
          i_or_d_o   = ADDR_ALU;
          if (mem_ready_i)
            next_state = WB_MEM;
          else if (timeout)
            next_state = TRAP;
        end
        WB_MEM: begin
          reg_write_o = 1'b1;
          wb_sel_o    = WB_SEL_MEM;
          retire_o    = 1'b1;
          next_state  = FETCH;
        end
        MEM_WR: begin
          mem_write_o = 1'b1;
          i_or_d_o    = ADDR_ALU;
          if (mem_ready_i) begin
            retire_o   = 1'b1;
            next_state = FETCH;
          end else if (timeout) begin
            next_state = TRAP;
          end
        end
        BRANCH: begin
          alu_src_a_o = SRC_A_RS1;
          alu_src_b_o = SRC_B_RT;
          alu_op_o    = ALU_SUB;
          pc_src_o    = PC_SRC_TGT;
          pc_write_o  = zero_i;
          retire_o    = 1'b1;
          next_state  = FETCH;
        end
        JAL, JALR: begin
          reg_write_o = 1'b1;
          wb_sel_o    = WB_SEL_PC4;
          pc_write_o  = 1'b1;
          pc_src_o    = PC_SRC_TGT;
          alu_src_a_o = (state == JALR) ? SRC_A_RS1 : SRC_A_OLD_PC;
          alu_src_b_o = SRC_B_IMM;
          retire_o    = 1'b1;
          next_state  = FETCH;
        end
        TRAP: begin
          trap_o     = 1'b1;
          next_state = TRAP;
        end
        default: begin
          next_state = TRAP;
        end
      endcase
    end
  end

  assign state_o = state;

  retire_counter #(
    .INIT (RETIRE_CNT_INIT)
  ) u_retire_counter (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (retire_o),
    .count (retired_cnt_o)
  );

endmodule
